// File: rtl/addr8s_block_accum_if.sv
// Handshake bundle between the 8-bit signed adder, the block accumulator and its consumer.
// master = adder/consumer side, slave = accumulator side.
interface addr8s_block_accum_if #(
    parameter int ACC_W   = 16,
    parameter int BLK_LEN = 8
);
    localparam int CNT_W = $clog2(BLK_LEN + 1);

    // Both handshakes use strict valid/ready: a transfer happens on a rising clk edge
    // where valid and ready are both 1; once raised, valid and its payload hold until then.
    logic [8:0]       sum_i;
    logic             in_valid;
    logic             in_ready;
    logic             flush;
    logic [ACC_W-1:0] out_data;
    logic [CNT_W-1:0] out_cnt;
    logic             out_ovf;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output sum_i, in_valid, flush, out_ready,
        input  in_ready, out_data, out_cnt, out_ovf, out_valid
    );

    modport slave (
        input  sum_i, in_valid, flush, out_ready,
        output in_ready, out_data, out_cnt, out_ovf, out_valid
    );
endinterface

// File: rtl/addr8s_block_accum.sv
// Accumulates BLK_LEN signed adder sums per block and presents the registered total.
// Define ADDR8S_ACC_SAT_EN to saturate the accumulator instead of wrapping.
module addr8s_block_accum #(
    parameter int ACC_W   = 16,
    parameter int BLK_LEN = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    addr8s_block_accum_if.slave  bus,
    output logic [1:0]           dbg_state
);
    localparam int CNT_W = $clog2(BLK_LEN + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [ACC_W-1:0] acc, acc_n, acc_step, add_raw, add_val, sum_ext;
    logic [CNT_W-1:0] cnt, cnt_n, cnt_step;
    logic             ovf, ovf_n, ovf_step, add_ovf;
    logic             accept, close, load_out, release_out;

    logic [ACC_W-1:0] out_data_r;
    logic [CNT_W-1:0] out_cnt_r;
    logic             out_ovf_r, out_valid_r;

    // Holding rst also blocks upstream so nothing is consumed during reset.
    assign bus.in_ready = (state != HOLD) && !rst;
    assign accept       = bus.in_valid && bus.in_ready;
    assign dbg_state    = state;

    assign sum_ext = {{(ACC_W-9){bus.sum_i[8]}}, bus.sum_i};
    assign add_raw = acc + sum_ext;
    assign add_ovf = (acc[ACC_W-1] == sum_ext[ACC_W-1]) && (add_raw[ACC_W-1] != acc[ACC_W-1]);

`ifdef ADDR8S_ACC_SAT_EN
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    // Overflow can only happen when both operands share a sign, so acc's sign picks the rail.
    assign add_val = add_ovf ? (acc[ACC_W-1] ? ACC_MIN : ACC_MAX) : add_raw;
`else
    assign add_val = add_raw;
`endif

    always_comb begin
        acc_step    = acc;
        cnt_step    = cnt;
        ovf_step    = ovf;
        state_n     = state;
        load_out    = 1'b0;
        release_out = 1'b0;
        if (accept) begin
            acc_step = add_val;
            cnt_step = cnt + CNT_W'(1);
            ovf_step = ovf | add_ovf;
        end
        acc_n = acc_step;
        cnt_n = cnt_step;
        ovf_n = ovf_step;
        // flush only counts once the block holds at least one sum (state ACCUM).
        close = (state != HOLD) &&
                ((accept && (cnt_step == CNT_W'(BLK_LEN))) || (bus.flush && (state == ACCUM)));
        case (state)
            IDLE, ACCUM: begin
                if (close) begin
                    state_n  = HOLD;
                    acc_n    = '0;
                    cnt_n    = '0;
                    ovf_n    = 1'b0;
                    load_out = 1'b1;
                end else if (cnt_step != '0) begin
                    state_n = ACCUM;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_n     = IDLE;
                    release_out = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_n;
            acc   <= acc_n;
            cnt   <= cnt_n;
            ovf   <= ovf_n;
        end
    end

    // Result registers keep their last value after the consumer takes them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_r  <= '0;
            out_cnt_r   <= '0;
            out_ovf_r   <= 1'b0;
            out_valid_r <= 1'b0;
        end else if (load_out) begin
            out_data_r  <= acc_step;
            out_cnt_r   <= cnt_step;
            out_ovf_r   <= ovf_step;
            out_valid_r <= 1'b1;
        end else if (release_out) begin
            out_valid_r <= 1'b0;
        end
    end

    assign bus.out_data  = out_data_r;
    assign bus.out_cnt   = out_cnt_r;
    assign bus.out_ovf   = out_ovf_r;
    assign bus.out_valid = out_valid_r;
endmodule
